// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory slave for the pipeline MEM stage.
// Accepts one load/store at a time over a valid/ready handshake and answers
// LATENCY edges after acceptance with a single-cycle resp_valid pulse.
// Storage is internal, byte-addressed and doubleword-organised (2^ADDR_W bytes).
// Optional feature macro: DMEM_SUBWORD_EN adds req_size for byte/half/word
// accesses; without it every access is a doubleword that must be 8-byte aligned.
module dmem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
`ifdef DMEM_SUBWORD_EN
  input  logic [1:0]        req_size,
`endif
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int WORDS = 2 ** (ADDR_W - 3);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [3:0]          r_countdown;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [63:0]         r_wdata;
  logic [63:0]         r_rdata;
  logic                r_err;
  logic [63:0]         r_mem [WORDS];

  logic [1:0]          w_size;
  logic                w_commit;
  logic                w_misaligned;
  logic [ADDR_W-4:0]   w_wordIdx;
  logic [2:0]          w_lane;
  logic [5:0]          w_shift;
  logic [7:0]          w_sizeMask;
  logic [7:0]          w_byteMask;
  logic [63:0]         w_bitMask;
  logic [63:0]         w_loadData;
  logic [63:0]         w_storeWord;

`ifdef DMEM_SUBWORD_EN
  logic [1:0]          r_size;
  assign w_size = r_size;
`else
  assign w_size = 2'd3;
`endif

  assign w_commit  = (r_state == WAIT) && (r_countdown == 4'd0);
  assign w_wordIdx = r_addr[ADDR_W-1:3];
  assign w_lane    = r_addr[2:0];
  assign w_shift   = {w_lane, 3'b000};

  // Decode alignment and the byte lanes touched by the latched access size
  always_comb begin
    w_misaligned = 1'b0;
    w_sizeMask   = 8'hFF;
    case (w_size)
      2'd0: begin w_misaligned = 1'b0;          w_sizeMask = 8'h01; end
      2'd1: begin w_misaligned = r_addr[0];     w_sizeMask = 8'h03; end
      2'd2: begin w_misaligned = |r_addr[1:0];  w_sizeMask = 8'h0F; end
      default: begin w_misaligned = |r_addr[2:0]; w_sizeMask = 8'hFF; end
    endcase
    w_byteMask = w_sizeMask << w_lane;
    w_bitMask  = '0;
    for (int i = 0; i < 8; i++) begin
      w_bitMask[i*8 +: 8] = {8{w_byteMask[i]}};
    end
    w_loadData  = (r_mem[w_wordIdx] & w_bitMask) >> w_shift;
    w_storeWord = (r_mem[w_wordIdx] & ~w_bitMask) | ((r_wdata << w_shift) & w_bitMask);
  end

  // State register; reset wins over everything, aborting any pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: a latency of 1 simply enters WAIT with a zero countdown
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = WAIT;
      WAIT:    if (r_countdown == 4'd0) w_nextState = RESP;
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Output decode: ready only when idle, response pulse only in RESP
  always_comb begin
    req_ready  = (r_state == IDLE);
    resp_valid = (r_state == RESP);
    resp_rdata = r_rdata;
    resp_err   = r_err;
  end

  // Request latch, countdown and response data; rdata is held after RESP
  always_ff @(posedge clk) begin
    if (reset) begin
      r_countdown <= 4'd0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
`ifdef DMEM_SUBWORD_EN
      r_size      <= 2'd3;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_countdown <= 4'(LATENCY - 1);
`ifdef DMEM_SUBWORD_EN
            r_size      <= req_size;
`endif
          end
        end
        WAIT: begin
          if (r_countdown != 4'd0) begin
            r_countdown <= r_countdown - 4'd1;
          end else begin
            r_err   <= w_misaligned;
            r_rdata <= (w_misaligned || r_write) ? 64'd0 : w_loadData;
          end
        end
        RESP: begin
          r_err <= 1'b0;
        end
        default: begin
          r_err <= 1'b0;
        end
      endcase
    end
  end

  // Storage: cleared on reset, written only by an aligned store at commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_commit && !w_misaligned && r_write) begin
      r_mem[w_wordIdx] <= w_storeWord;
    end
  end

endmodule
